event_window_accumulator: RTL and testbench

//  Producer side of the window-sum interface consumed by MotionComputer.
//  - Accepts DVS events over a valid/ready handshake.
//  - Splits time into back-to-back early and late windows, each WINDOW_CYCLES long.
//  - Per window, accumulates signed centred coordinate sums and event counts.
//  - After every late window, presents both windows' results and pulses trigger.

---
 rtl/event_window_accumulator.sv | 222 ++++++++++++++++++++++
 tb/tb_event_window_accumulator.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_window_accumulator.sv
// Event window accumulator: producer side of the window-sum interface read by
// MotionComputer. Accepts DVS events over valid/ready, splits time into
// back-to-back early and late windows of WINDOW_CYCLES each, accumulates
// centred signed coordinate sums and event counts per window, and after every
// late window presents both windows' results with a one-cycle trigger pulse.
module event_window_accumulator #(
  parameter int X_BITS         = 7,
  parameter int Y_BITS         = 7,
  parameter int ACC_SUM_BITS   = 18,
  parameter int ACC_COUNT_BITS = 12,
  parameter int WINDOW_CYCLES  = 600000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      ev_valid,
  input  logic [X_BITS-1:0]         ev_x,
  input  logic [Y_BITS-1:0]         ev_y,
  output logic                      ev_ready,
  output logic                      trigger,
  output logic [ACC_SUM_BITS-1:0]   early_sum_x,
  output logic [ACC_SUM_BITS-1:0]   early_sum_y,
  output logic [ACC_COUNT_BITS-1:0] early_count,
  output logic [ACC_SUM_BITS-1:0]   late_sum_x,
  output logic [ACC_SUM_BITS-1:0]   late_sum_y,
  output logic [ACC_COUNT_BITS-1:0] late_count
);

  localparam int CNT_BITS = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] LAST_CYCLE = CNT_BITS'(WINDOW_CYCLES - 1);

  // Midpoints of the coordinate ranges; XOR with these flips the MSB, which
  // is exactly "value minus 2^(BITS-1)" in two's complement.
  localparam logic [X_BITS-1:0] X_MID = X_BITS'(1) << (X_BITS - 1);
  localparam logic [Y_BITS-1:0] Y_MID = Y_BITS'(1) << (Y_BITS - 1);

  localparam logic [ACC_SUM_BITS-1:0] SUM_MAX = {1'b0, {(ACC_SUM_BITS-1){1'b1}}};
  localparam logic [ACC_SUM_BITS-1:0] SUM_MIN = {1'b1, {(ACC_SUM_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EARLY,
    ST_LATE,
    ST_EMIT
  } state_t;

  // One window's running results.
  typedef struct packed {
    logic [ACC_SUM_BITS-1:0]   sum_x;
    logic [ACC_SUM_BITS-1:0]   sum_y;
    logic [ACC_COUNT_BITS-1:0] count;
  } win_acc_t;

  state_t                state_q, state_nxt;
  logic [CNT_BITS-1:0]   win_cnt_q, win_cnt_nxt;

  win_acc_t              early_q, late_q;
  win_acc_t              early_nxt, late_nxt;
  win_acc_t              early_out_q, late_out_q;

  logic                  ev_accept;
  logic [ACC_SUM_BITS-1:0] ev_off_x, ev_off_y;

  // Centre an x coordinate around zero and sign-extend to the sum width.
  function automatic logic [ACC_SUM_BITS-1:0] centre_x(input logic [X_BITS-1:0] v);
    logic [X_BITS-1:0] off;
    off = v ^ X_MID;
    return {{(ACC_SUM_BITS-X_BITS){off[X_BITS-1]}}, off};
  endfunction

  // Centre a y coordinate around zero and sign-extend to the sum width.
  function automatic logic [ACC_SUM_BITS-1:0] centre_y(input logic [Y_BITS-1:0] v);
    logic [Y_BITS-1:0] off;
    off = v ^ Y_MID;
    return {{(ACC_SUM_BITS-Y_BITS){off[Y_BITS-1]}}, off};
  endfunction

  // Signed add that clamps at the representable extremes instead of wrapping.
  function automatic logic [ACC_SUM_BITS-1:0] sat_add(input logic [ACC_SUM_BITS-1:0] acc,
                                                      input logic [ACC_SUM_BITS-1:0] d);
    logic [ACC_SUM_BITS:0] wide;
    wide = {acc[ACC_SUM_BITS-1], acc} + {d[ACC_SUM_BITS-1], d};
    if (wide[ACC_SUM_BITS] != wide[ACC_SUM_BITS-1]) begin
      return wide[ACC_SUM_BITS] ? SUM_MIN : SUM_MAX;
    end
    return wide[ACC_SUM_BITS-1:0];
  endfunction

  // Fold one event into a window. A saturated count freezes the whole window,
  // so sums and count always describe the same set of events.
  function automatic win_acc_t accumulate(input win_acc_t acc,
                                          input logic [ACC_SUM_BITS-1:0] dx,
                                          input logic [ACC_SUM_BITS-1:0] dy);
    win_acc_t res;
    res = acc;
    if (!(&acc.count)) begin
      res.sum_x = sat_add(acc.sum_x, dx);
      res.sum_y = sat_add(acc.sum_y, dy);
      res.count = acc.count + 1'b1;
    end
    return res;
  endfunction

  assign ev_accept = ev_valid && ev_ready;
  assign ev_off_x  = centre_x(ev_x);
  assign ev_off_y  = centre_y(ev_y);

  // Next-state and window-counter logic; enable low overrides every state.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_nxt   = state_q;
    win_cnt_nxt = win_cnt_q;
    if (!enable) begin
      state_nxt   = ST_IDLE;
      win_cnt_nxt = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_nxt   = ST_EARLY;
          win_cnt_nxt = '0;
        end
        ST_EARLY: begin
          if (win_cnt_q == LAST_CYCLE) begin
            state_nxt   = ST_LATE;
            win_cnt_nxt = '0;
          end else begin
            win_cnt_nxt = win_cnt_q + 1'b1;
          end
        end
        ST_LATE: begin
          if (win_cnt_q == LAST_CYCLE) begin
            state_nxt   = ST_EMIT;
            win_cnt_nxt = '0;
          end else begin
            win_cnt_nxt = win_cnt_q + 1'b1;
          end
        end
        ST_EMIT: begin
          state_nxt   = ST_EARLY;
          win_cnt_nxt = '0;
        end
        default: begin
          state_nxt   = ST_IDLE;
          win_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Route an accepted event into the window that is open on this cycle.
  always_comb begin
    early_nxt = early_q;
    late_nxt  = late_q;
    if (ev_accept && (state_q == ST_EARLY)) begin
      early_nxt = accumulate(early_q, ev_off_x, ev_off_y);
    end
    if (ev_accept && (state_q == ST_LATE)) begin
      late_nxt = accumulate(late_q, ev_off_x, ev_off_y);
    end
  end

  // State and window counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_nxt;
      win_cnt_q <= win_cnt_nxt;
    end
  end

  // Registered decodes of the upcoming state: ready while a window is open,
  // trigger for the single EMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_ready <= 1'b0;
      trigger  <= 1'b0;
    end else begin
      ev_ready <= (state_nxt == ST_EARLY) || (state_nxt == ST_LATE);
      trigger  <= (state_nxt == ST_EMIT);
    end
  end

  // Window accumulators; cleared on leaving the windows, either to EMIT
  // (results handed over) or to IDLE (partial window discarded).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      early_q <= '0;
      late_q  <= '0;
    end else if ((state_nxt == ST_IDLE) || (state_nxt == ST_EMIT)) begin
      early_q <= '0;
      late_q  <= '0;
    end else begin
      early_q <= early_nxt;
      late_q  <= late_nxt;
    end
  end

  // Result registers: capture the final window values, including an event
  // accepted on the last LATE cycle, on the edge that raises trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      early_out_q <= '0;
      late_out_q  <= '0;
    end else if (state_nxt == ST_EMIT) begin
      early_out_q <= early_nxt;
      late_out_q  <= late_nxt;
    end
  end

  assign early_sum_x = early_out_q.sum_x;
  assign early_sum_y = early_out_q.sum_y;
  assign early_count = early_out_q.count;
  assign late_sum_x  = late_out_q.sum_x;
  assign late_sum_y  = late_out_q.sum_y;
  assign late_count  = late_out_q.count;

endmodule

// File: tb/tb_event_window_accumulator.sv
// Bench for event_window_accumulator: two instances (short windows for
// timing/boundary cases, long windows for saturation), a time-indexed
// behavioural model compared every cycle, and hand-computed expectations.
`timescale 1ns/1ps
module tb_event_window_accumulator;

  localparam int XB = 7;
  localparam int YB = 7;
  localparam int SB = 18;
  localparam int CB = 12;
  localparam int W0 = 16;
  localparam int W1 = 5000;
  localparam int SUM_MAX = 2 ** (SB - 1) - 1;
  localparam int SUM_MIN = -(2 ** (SB - 1));
  localparam int CNT_MAX = 2 ** CB - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en  [2];
  logic          vld [2];
  logic [XB-1:0] xv  [2];
  logic [YB-1:0] yv  [2];
  logic          rdy [2];
  logic          trg [2];
  logic [SB-1:0] esx [2];
  logic [SB-1:0] esy [2];
  logic [CB-1:0] ec  [2];
  logic [SB-1:0] lsx [2];
  logic [SB-1:0] lsy [2];
  logic [CB-1:0] lc  [2];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  event_window_accumulator #(
    .X_BITS(XB), .Y_BITS(YB), .ACC_SUM_BITS(SB), .ACC_COUNT_BITS(CB), .WINDOW_CYCLES(W0)
  ) dut_fast (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .ev_valid(vld[0]), .ev_x(xv[0]), .ev_y(yv[0]),
    .ev_ready(rdy[0]), .trigger(trg[0]),
    .early_sum_x(esx[0]), .early_sum_y(esy[0]), .early_count(ec[0]),
    .late_sum_x(lsx[0]), .late_sum_y(lsy[0]), .late_count(lc[0])
  );

  event_window_accumulator #(
    .X_BITS(XB), .Y_BITS(YB), .ACC_SUM_BITS(SB), .ACC_COUNT_BITS(CB), .WINDOW_CYCLES(W1)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .ev_valid(vld[1]), .ev_x(xv[1]), .ev_y(yv[1]),
    .ev_ready(rdy[1]), .trigger(trg[1]),
    .early_sum_x(esx[1]), .early_sum_y(esy[1]), .early_count(ec[1]),
    .late_sum_x(lsx[1]), .late_sum_y(lsy[1]), .late_count(lc[1])
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int w_of(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic int clamp(input int v);
    if (v > SUM_MAX) return SUM_MAX;
    if (v < SUM_MIN) return SUM_MIN;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  // Time is tracked as the position t within the 2W+1 cycle period:
  // t in [0,W) early window, [W,2W) late window, t == 2W the emit cycle.
  bit m_run [2];
  int m_t   [2];
  int m_esx [2], m_esy [2], m_ec [2], m_lsx [2], m_lsy [2], m_lc [2];
  int x_esx [2], x_esy [2], x_ec [2], x_lsx [2], x_lsy [2], x_lc [2];
  bit x_trg [2], x_rdy [2];

  task automatic clear_acc(input int i);
    m_esx[i] = 0; m_esy[i] = 0; m_ec[i] = 0;
    m_lsx[i] = 0; m_lsy[i] = 0; m_lc[i] = 0;
  endtask

  task automatic model_edge(input int i);
    int w, ox, oy;
    w = w_of(i);
    if (!rst_n) begin
      m_run[i] = 1'b0;
      m_t[i]   = 0;
      clear_acc(i);
      x_esx[i] = 0; x_esy[i] = 0; x_ec[i] = 0;
      x_lsx[i] = 0; x_lsy[i] = 0; x_lc[i] = 0;
      x_trg[i] = 1'b0;
      x_rdy[i] = 1'b0;
    end else begin
      x_trg[i] = 1'b0;
      if (!en[i]) begin
        m_run[i] = 1'b0;
        m_t[i]   = 0;
        clear_acc(i);
      end else if (!m_run[i]) begin
        m_run[i] = 1'b1;
        m_t[i]   = 0;
      end else begin
        if (vld[i] && (m_t[i] < 2 * w)) begin
          ox = int'(xv[i]) - 2 ** (XB - 1);
          oy = int'(yv[i]) - 2 ** (YB - 1);
          if (m_t[i] < w) begin
            if (m_ec[i] < CNT_MAX) begin
              m_esx[i] = clamp(m_esx[i] + ox);
              m_esy[i] = clamp(m_esy[i] + oy);
              m_ec[i]++;
            end
          end else begin
            if (m_lc[i] < CNT_MAX) begin
              m_lsx[i] = clamp(m_lsx[i] + ox);
              m_lsy[i] = clamp(m_lsy[i] + oy);
              m_lc[i]++;
            end
          end
        end
        if (m_t[i] == 2 * w - 1) begin
          x_esx[i] = m_esx[i]; x_esy[i] = m_esy[i]; x_ec[i] = m_ec[i];
          x_lsx[i] = m_lsx[i]; x_lsy[i] = m_lsy[i]; x_lc[i] = m_lc[i];
          clear_acc(i);
          x_trg[i] = 1'b1;
          m_t[i]   = 2 * w;
        end else if (m_t[i] == 2 * w) begin
          m_t[i] = 0;
        end else begin
          m_t[i]++;
        end
      end
      x_rdy[i] = m_run[i] && (m_t[i] < 2 * w);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) model_edge(i);
    end
  end

  // Compare both instances against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("i%0d ev_ready", i), rdy[i], x_rdy[i]);
        check($sformatf("i%0d trigger", i), trg[i], x_trg[i]);
        check($sformatf("i%0d early_sum_x", i), $signed(esx[i]), x_esx[i]);
        check($sformatf("i%0d early_sum_y", i), $signed(esy[i]), x_esy[i]);
        check($sformatf("i%0d early_count", i), ec[i], x_ec[i]);
        check($sformatf("i%0d late_sum_x", i), $signed(lsx[i]), x_lsx[i]);
        check($sformatf("i%0d late_sum_y", i), $signed(lsy[i]), x_lsy[i]);
        check($sformatf("i%0d late_count", i), lc[i], x_lc[i]);
      end
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ev(input int i, input logic v, input logic [XB-1:0] x, input logic [YB-1:0] y);
    vld[i] = v;
    xv[i]  = x;
    yv[i]  = y;
  endtask

  task automatic wait_trig(input int i, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((trg[i] !== 1'b1) && (cyc < budget));
    if (trg[i] !== 1'b1) check($sformatf("i%0d trigger timeout", i), trg[i], 1);
  endtask

  task automatic check_outs(input string tag, input int i, input int e_x, input int e_y,
                            input int e_c, input int l_x, input int l_y, input int l_c);
    check({tag, " early_sum_x"}, $signed(esx[i]), e_x);
    check({tag, " early_sum_y"}, $signed(esy[i]), e_y);
    check({tag, " early_count"}, ec[i], e_c);
    check({tag, " late_sum_x"}, $signed(lsx[i]), l_x);
    check({tag, " late_sum_y"}, $signed(lsy[i]), l_y);
    check({tag, " late_count"}, lc[i], l_c);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k, c, stray;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0;
      set_ev(i, 1'b0, '0, '0);
    end
    rst_n = 1'b0;
    step(3);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset i%0d ev_ready", i), rdy[i], 0);
      check($sformatf("reset i%0d trigger", i), trg[i], 0);
      check_outs($sformatf("reset i%0d", i), i, 0, 0, 0, 0, 0, 0);
    end
    rst_n = 1'b1;
    step(1);

    // T2 basic: one early and one late event.
    en[0] = 1'b1;
    step(1); k = 1;
    check("T2 ev_ready in early", rdy[0], 1);
    set_ev(0, 1'b1, 7'd70, 7'd60);
    step(1); k = 2;
    set_ev(0, 1'b0, '0, '0);
    step(W0 + 1); k = W0 + 3;
    set_ev(0, 1'b1, 7'd80, 7'd60);
    step(1); k++;
    set_ev(0, 1'b0, '0, '0);
    wait_trig(0, 3 * W0, c); k += c;
    check("T2 trigger cycle", k, 33);
    check_outs("T2", 0, 6, -4, 1, 16, -4, 1);
    check("T2 ev_ready in emit", rdy[0], 0);

    // T3 boundary: event held through EMIT, last early cycle, first late cycle.
    set_ev(0, 1'b1, 7'd10, 7'd20);
    step(1); k = 1;
    check("T3 ev_ready after emit", rdy[0], 1);
    step(1); k = 2;
    set_ev(0, 1'b0, '0, '0);
    step(W0 - 2); k = W0;
    set_ev(0, 1'b1, 7'd100, 7'd0);
    step(1); k++;
    set_ev(0, 1'b1, 7'd0, 7'd127);
    step(1); k++;
    set_ev(0, 1'b0, '0, '0);
    wait_trig(0, 3 * W0, c); k += c;
    check("T3 trigger cycle", k, 33);
    check_outs("T3", 0, -18, -108, 2, -64, 63, 1);

    // T5 enable drop mid-late; following window has no events.
    step(3);
    set_ev(0, 1'b1, 7'd127, 7'd127);
    step(1);
    set_ev(0, 1'b0, '0, '0);
    step(W0 - 2);
    set_ev(0, 1'b1, 7'd1, 7'd1);
    step(1);
    set_ev(0, 1'b0, '0, '0);
    step(2);
    en[0] = 1'b0;
    step(1);
    check("T5 ev_ready after drop", rdy[0], 0);
    check("T5 trigger after drop", trg[0], 0);
    en[0] = 1'b1;
    step(1); k = 1;
    wait_trig(0, 3 * W0, c); k += c;
    check("T5 trigger cycle", k, 33);
    check_outs("T5", 0, 0, 0, 0, 0, 0, 0);

    // T6 three back-to-back windows with distinct event patterns.
    stray = 0;
    for (int j = 0; j < 3; j++) begin
      for (int kk = 1; kk <= 2 * W0 + 1; kk++) begin
        step(1);
        if (kk < 2 * W0 + 1) begin
          if (trg[0] === 1'b1) stray++;
        end else begin
          check($sformatf("T6 window %0d trigger", j), trg[0], 1);
        end
        if ((kk <= 2 * W0) && ((kk % (3 + j)) == 1))
          set_ev(0, 1'b1, 7'((kk * 7 + j * 13) % 128), 7'((kk * 11 + j * 5) % 128));
        else
          set_ev(0, 1'b0, '0, '0);
      end
    end
    check("T6 stray triggers", stray, 0);

    // T1 reset mid-late: immediate clear, restart timing.
    step(1);
    set_ev(0, 1'b1, 7'd90, 7'd30);
    step(1);
    set_ev(0, 1'b0, '0, '0);
    step(W0 + 1);
    #2 rst_n = 1'b0;
    #1;
    check("T1 ev_ready in reset", rdy[0], 0);
    check("T1 trigger in reset", trg[0], 0);
    check_outs("T1 in reset", 0, 0, 0, 0, 0, 0, 0);
    step(2);
    rst_n = 1'b1;
    step(1); k = 1;
    wait_trig(0, 3 * W0, c); k += c;
    check("T1 trigger cycle", k, 33);
    check_outs("T1 after", 0, 0, 0, 0, 0, 0, 0);

    // T4 saturation on the long-window instance, positive then negative.
    en[1] = 1'b1;
    step(1); k = 1;
    set_ev(1, 1'b1, 7'd127, 7'd64);
    step(4100); k += 4100;
    set_ev(1, 1'b0, '0, '0);
    wait_trig(1, 2 * W1 + 10, c); k += c;
    check("T4 trigger cycle", k, 10001);
    check_outs("T4 pos", 1, 131071, 0, 4095, 0, 0, 0);
    set_ev(1, 1'b1, 7'd0, 7'd127);
    step(1); k = 1;
    step(4100); k += 4100;
    set_ev(1, 1'b0, '0, '0);
    wait_trig(1, 2 * W1 + 10, c); k += c;
    check("T4 neg trigger cycle", k, 10001);
    check_outs("T4 neg", 1, -131072, 131071, 4095, 0, 0, 0);

    en[1] = 1'b0;
    en[0] = 1'b0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
